// File: rtl/run_detector.sv
// Run-length detector: flags when the last RUN_LEN accepted samples of w are equal,
// with polarity qualification, run visibility, a saturating event counter and a sticky hit.
module run_detector #(
  parameter  int RUN_LEN = 4,
  parameter  int CNT_W   = 8,
  localparam int RW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr_hit,
  output logic             z,
  output logic [RW-1:0]    run_len,
  output logic             last_bit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             hit
);

  typedef enum logic [1:0] {
    MODE_BOTH  = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_ZEROS = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
  localparam logic [RW-1:0]    RUN_ONE = RW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic qual(input logic b, input logic [1:0] m);
    case (mode_e'(m))
      MODE_BOTH:  qual = 1'b1;
      MODE_ONES:  qual = b;
      MODE_ZEROS: qual = ~b;
      default:    qual = 1'b0;
    endcase
  endfunction

  logic             r_valid;
  logic             r_last_bit;
  logic [RW-1:0]    r_run_len;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_hit;

  logic             w_new_run;
  logic [RW-1:0]    w_run_next;
  logic             w_event;

  always_comb begin
    w_new_run  = !r_valid || (w != r_last_bit);
    w_run_next = r_run_len;
    if (w_new_run) begin
      w_run_next = RUN_ONE;
    end else if (r_run_len != RUN_MAX) begin
      w_run_next = r_run_len + RUN_ONE;
    end
    // A saturated run that simply continues is not a new event; only a run that
    // just reached RUN_LEN (or restarted straight into it when RUN_LEN=1) counts.
    w_event = enable && (w_run_next == RUN_MAX)
              && ((r_run_len < RUN_MAX) || (w != r_last_bit))
              && qual(w, mode);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_last_bit  <= 1'b0;
      r_run_len   <= '0;
      r_match_cnt <= '0;
      r_hit       <= 1'b0;
    end else begin
      if (enable) begin
        r_valid    <= 1'b1;
        r_last_bit <= w;
        r_run_len  <= w_run_next;
      end
      if (w_event) begin
        if (r_match_cnt != '1) begin
          r_match_cnt <= r_match_cnt + CNT_ONE;
        end
        r_hit <= 1'b1;
      end else if (clr_hit) begin
        r_hit <= 1'b0;
      end
    end
  end

  // Moore output: mode is deliberately unregistered so it gates z immediately.
  assign z         = (r_run_len == RUN_MAX) && qual(r_last_bit, mode);
  assign run_len   = r_run_len;
  assign last_bit  = r_last_bit;
  assign match_cnt = r_match_cnt;
  assign hit       = r_hit;

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: three configurations share one stimulus stream; a scoreboard
// of model predictions is checked after every edge, plus directed checks at key points.
module tb_run_detector;

  logic       clock = 1'b0;
  logic       reset, enable, w, clr_hit;
  logic [1:0] mode;

  logic       z4, last4, hit4;
  logic [2:0] run4;
  logic [7:0] cnt4;
  logic       z1, last1, hit1;
  logic [0:0] run1;
  logic [7:0] cnt1;
  logic       z2, last2, hit2;
  logic [1:0] run2;
  logic [1:0] cnt2;

  always #5 clock = ~clock;

  run_detector #(.RUN_LEN(4), .CNT_W(8)) u4 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode), .clr_hit(clr_hit),
    .z(z4), .run_len(run4), .last_bit(last4), .match_cnt(cnt4), .hit(hit4));
  run_detector #(.RUN_LEN(1), .CNT_W(8)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode), .clr_hit(clr_hit),
    .z(z1), .run_len(run1), .last_bit(last1), .match_cnt(cnt1), .hit(hit1));
  run_detector #(.RUN_LEN(2), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .mode(mode), .clr_hit(clr_hit),
    .z(z2), .run_len(run2), .last_bit(last2), .match_cnt(cnt2), .hit(hit2));

  typedef struct {
    string tag;
    int    idx;
    int    z;
    int    run;
    int    last;
    int    cnt;
    int    hit;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  int rl[3]   = '{4, 1, 2};
  int cmax[3] = '{255, 255, 3};
  int m_valid[3], m_last[3], m_run[3], m_cnt[3], m_hit[3];

  function automatic int qual_m(input int b, input logic [1:0] md);
    case (md)
      2'b00:   return 1;
      2'b01:   return b;
      2'b10:   return (b == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int model_z(input int i);
    return (m_run[i] == rl[i] && qual_m(m_last[i], mode) != 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int i, output logic [31:0] oz, output logic [31:0] orun,
                         output logic [31:0] olast, output logic [31:0] ocnt,
                         output logic [31:0] ohit);
    case (i)
      0:       begin oz = z4; orun = run4; olast = last4; ocnt = cnt4; ohit = hit4; end
      1:       begin oz = z1; orun = run1; olast = last1; ocnt = cnt1; ohit = hit1; end
      default: begin oz = z2; orun = run2; olast = last2; ocnt = cnt2; ohit = hit2; end
    endcase
  endtask

  // Reference behaviour for one clock edge, applied to every configuration.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int nr;
      int ev;
      nr = m_run[i];
      ev = 0;
      if (reset) begin
        m_valid[i] = 0; m_last[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_hit[i] = 0;
      end else begin
        if (enable) begin
          if (m_valid[i] == 0 || int'(w) != m_last[i]) nr = 1;
          else nr = (m_run[i] + 1 > rl[i]) ? rl[i] : m_run[i] + 1;
          ev = (nr == rl[i] && (m_run[i] < rl[i] || int'(w) != m_last[i])
                && qual_m(int'(w), mode) != 0) ? 1 : 0;
          m_run[i] = nr; m_last[i] = int'(w); m_valid[i] = 1;
        end
        if (ev != 0) begin
          if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
          m_hit[i] = 1;
        end else if (clr_hit) begin
          m_hit[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic wv, input logic clr,
                      input string tag);
    exp_t e;
    logic [31:0] oz, orun, olast, ocnt, ohit;
    reset = rst; enable = en; w = wv; clr_hit = clr;
    model_edge();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{tag, i, model_z(i), m_run[i], m_last[i], m_cnt[i], m_hit[i]});
    end
    @(posedge clock);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      get_obs(e.idx, oz, orun, olast, ocnt, ohit);
      check($sformatf("%s/u%0d.z", e.tag, e.idx), oz, e.z);
      check($sformatf("%s/u%0d.run_len", e.tag, e.idx), orun, e.run);
      check($sformatf("%s/u%0d.last_bit", e.tag, e.idx), olast, e.last);
      check($sformatf("%s/u%0d.match_cnt", e.tag, e.idx), ocnt, e.cnt);
      check($sformatf("%s/u%0d.hit", e.tag, e.idx), ohit, e.hit);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_w[6]   = '{1, 1, 1, 1, 1, 0};
    int b_run[6] = '{1, 2, 3, 4, 4, 1};
    int b_z[6]   = '{0, 0, 0, 1, 1, 0};
    int g_en[7]  = '{1, 0, 1, 0, 1, 0, 1};
    int g_run[7] = '{1, 1, 2, 2, 3, 3, 4};

    mode = 2'b00;
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    check("reset.z", z4, 0);
    check("reset.run_len", run4, 0);
    check("reset.match_cnt", cnt4, 0);
    check("reset.hit", hit4, 0);

    // Basic run, both polarities.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, b_w[i][0], 1'b0, "basic");
      check($sformatf("basic.run_len[%0d]", i), run4, b_run[i]);
      check($sformatf("basic.z[%0d]", i), z4, b_z[i]);
    end
    check("basic.match_cnt", cnt4, 1);
    check("basic.hit", hit4, 1);

    // Zeros only.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, (i >= 4), 1'b0, "zeros");
      check($sformatf("zeros.z[%0d]", i), z4, (i == 3) ? 1 : 0);
    end
    check("zeros.match_cnt", cnt4, 1);

    // Enable gaps do not break a run.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    mode = 2'b00;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, g_en[i][0], 1'b1, 1'b0, "gaps");
      check($sformatf("gaps.run_len[%0d]", i), run4, g_run[i]);
      check($sformatf("gaps.z[%0d]", i), z4, (i == 6) ? 1 : 0);
    end

    // Reset mid-run discards history.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, "midrun");
    step(1'b1, 1'b1, 1'b1, 1'b0, "midrun_rst");
    check("midrun_rst.z", z4, 0);
    check("midrun_rst.run_len", run4, 0);
    check("midrun_rst.last_bit", last4, 0);
    check("midrun_rst.match_cnt", cnt4, 0);
    check("midrun_rst.hit", hit4, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, "post_rst");
      check($sformatf("post_rst.z[%0d]", i), z4, (i == 3) ? 1 : 0);
    end
    check("post_rst.match_cnt", cnt4, 1);

    // RUN_LEN=1 events and hit clear priority.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, "rl1");
    check("rl1.first_event_cnt", cnt1, 1);
    check("rl1.first_z", z1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, "rl1");
    step(1'b0, 1'b1, 1'b1, 1'b1, "rl1_clr_noevent");
    check("rl1.clr_noevent_hit", hit1, 0);
    check("rl1.continue_cnt", cnt1, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1, "rl1_clr_event");
    check("rl1.clr_event_hit", hit1, 1);
    check("rl1.match_cnt", cnt1, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1, "rl1_clr_idle");
    check("rl1.clr_idle_hit", hit1, 0);

    // Saturation with CNT_W=2, RUN_LEN=2, then mode 11 gating z immediately.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, ((k / 2) % 2) != 0, 1'b0, "sat");
    check("sat.match_cnt", cnt2, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, "sat_cont");
    check("sat_cont.z", z2, 1);
    check("sat_cont.match_cnt", cnt2, 3);
    mode = 2'b11;
    #1;
    check("mode_off.z", z2, 0);
    check("mode_off.model_z", z2, model_z(2));
    check("mode_off.run_len", run2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length detector for the serial input `w`. It flags when the last `RUN_LEN` accepted samples are all equal, and a mode select chooses whether runs of 1s, runs of 0s, or both qualify. It also provides sample enable, current-run visibility, a saturating detection counter and a sticky hit flag. It is the general-purpose successor to the fixed four-in-a-row sequence detector and is driven from switches and a push-button clock, or from any internal sampled bit stream.

## Interface
- `RUN_LEN`, 4: equal-sample run length that asserts `z`. Legal range 1..255.
- `CNT_W`, 8: width of `match_cnt`.
- Derived, not overridable: `RW = $clog2(RUN_LEN+1)`, the width of `run_len`.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; highest priority.
- `enable` in 1: sample strobe; `w` is accepted only on edges where `enable=1`.
- `w` in 1: serial data bit.
- `mode` in 2: 00 = both polarities, 01 = ones only, 10 = zeros only, 11 = detection disabled (counting continues).
- `clr_hit` in 1: synchronous clear of `hit`.
- `z` out 1: run detected (Moore output).
- `run_len` out RW: length of the current run, saturating at `RUN_LEN`.
- `last_bit` out 1: value of the most recently accepted sample.
- `match_cnt` out CNT_W: number of qualifying detections, saturating.
- `hit` out 1: sticky detection flag.

## Operation
- Registered state:
  - `valid`: at least one sample has been accepted since reset.
  - `last_bit`.
  - `run_len`.
  - `match_cnt`.
  - `hit`.
- On reset, all registers clear: `valid=0`, `last_bit=0`, `run_len=0`, `match_cnt=0`, `hit=0`. Therefore `z=0`.
- On an edge with `enable=0`, no register changes, except `hit` clears if `clr_hit=1`.
- On an edge with `enable=1`:
  - If `valid=0` or `w != last_bit`: `run_len <= 1`.
  - Otherwise: `run_len <= min(run_len+1, RUN_LEN)`.
  - `last_bit <= w` and `valid <= 1`.
- `z = (run_len == RUN_LEN) & qual(last_bit)`, where:
  - `qual(b)` = 1 for mode 00.
  - `qual(b)` = b for mode 01.
  - `qual(b)` = ~b for mode 10.
  - `qual(b)` = 0 for mode 11.
- Runs overlap: `z` stays high while equal samples continue. `z` drops on the first accepted differing sample, unless `RUN_LEN=1`.
- A new detection event happens on an enabled edge where:
  - next `run_len == RUN_LEN`, and
  - either the current `run_len < RUN_LEN` or `w != last_bit` (a new run just completed), and
  - `qual(w)` holds under the `mode` present at that edge.
- On a new detection event:
  - `match_cnt <= match_cnt+1`, saturating at all-ones.
  - `hit <= 1`.
- A continuing saturated run is not a new event, so it does not increment `match_cnt`.
- `hit` behaviour:
  - Set by a detection event.
  - Cleared by `clr_hit`.
  - If both occur on the same edge, set wins.
- `mode` is not registered:
  - A change affects `z` combinationally in the same cycle.
  - A change affects detection events only on subsequent edges.
  - A change never alters `run_len`.
- `RUN_LEN=1`: every enabled sample that starts a new run (including the first after reset) is an event, provided it qualifies.

## Timing
- `z`, `run_len`, `last_bit`, `match_cnt` and `hit` all update on the edge that accepts the completing sample. There are 0 cycles of extra latency.
- `z` depends only on registers and `mode`; there is no combinational path from `w` or `enable`.
- Reset mid-run discards all history. The next `RUN_LEN` enabled samples are needed before `z` can assert again.
- Idle gaps (`enable=0`) do not break a run; the run resumes on the next enabled sample.

## Test plan
- **Basic run, both polarities.** `RUN_LEN=4`, `mode=00`, `enable=1`, `w` = 1,1,1,1,1,0.
  - `run_len` = 1,2,3,4,4,1.
  - `z` is high after the 4th and 5th edges and low after the 6th.
  - `match_cnt=1`, `hit=1`.
- **Zeros only.** `mode=10`, `w` = 0,0,0,0 then 1,1,1,1.
  - `z` is high after the 4th edge and low after the 8th.
  - `match_cnt=1`.
- **Enable gaps.** `w=1` with `enable` pattern 1,0,1,0,1,0,1.
  - `z` asserts only on the edge of the 4th enabled sample.
  - `run_len` holds its value during the gaps.
- **Reset mid-run.** Reset after three 1s, then four 1s.
  - After reset, all outputs are 0.
  - `z` asserts on the 4th post-reset edge.
  - `match_cnt=1`.
- **`hit` clear priority and `RUN_LEN=1`.** `RUN_LEN=1`, `mode=00`, `w` = 0,1,1,0.
  - `match_cnt=3`.
  - `clr_hit=1` on the same edge as an event leaves `hit=1`.
  - `clr_hit=1` on an edge with no event gives `hit=0`.
- **Saturation.** `CNT_W=2`, `RUN_LEN=2`, `w` alternating in pairs (0,0,1,1,...) over 6 runs.
  - `match_cnt` stops at 3.
  - Mode switched to 11 mid-run drops `z` in the same cycle.
